de_mw_pipe_regs: RTL and testbench
==================================

# de_mw_pipe_regs

Pipeline-register bank for the D→E, E→M and M→W boundaries of the 5-stage core. It sits directly downstream of the hazard unit. It consumes `flushEX` to insert bubbles into E. It produces the per-stage destination register and Tnew values (`A3_E`/`Tnew_E`, `A3_M`/`Tnew_M`) that the hazard unit compares against in the following cycle. It also carries W-stage write information for forwarding and the register file, and keeps a saturating bubble counter for performance debug.

## Interface
Parameters:
- CTRL_W, 16, width of the opaque decoded control bundle carried through the stages
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  single clock; every register updates on its rising edge
- reset  in  1  synchronous, active-high reset
- flushEX  in  1  from hazard unit; replaces the D→E transfer with a bubble
- instr_D, pc_D, rs_data_D, rt_data_D, imm_D  in  32 each  D-stage instruction, PC, register-file read data and extended immediate
- ctrl_D  in  CTRL_W  D-stage decoded control
- A3_D  in  5  D-stage destination register (0 = no write)
- Tnew_D  in  2  cycles from entering E until the result is produced
- instr_E, pc_E, rs_data_E, rt_data_E, imm_E  out  32 each  E-stage copies
- ctrl_E  out  CTRL_W
- A3_E  out  5
- Tnew_E  out  2
- valid_E  out  1  0 when E holds a bubble
- alu_res_E  in  32  E-stage result, captured into M
- pc_M, alu_res_M, rt_data_M  out  32 each
- ctrl_M  out  CTRL_W
- A3_M  out  5
- Tnew_M  out  2
- valid_M  out  1
- mem_rdata_M  in  32  M-stage load data, captured into W
- pc_W, alu_res_W, mem_rdata_W  out  32 each
- ctrl_W  out  CTRL_W
- A3_W  out  5
- valid_W  out  1
- bubble_cnt  out  CNT_W  number of bubbles inserted since reset

## Operation
- The block never stalls: E, M and W advance every cycle. IF/D hold is handled outside this block via `stallPC`/`stallID`.
- D→E transfer, normal case: each `*_E` register loads its `*_D` input and `valid_E` is set to 1.
- D→E transfer when `flushEX`=1:
  - `instr_E`, `rs_data_E`, `rt_data_E`, `imm_E`, `ctrl_E`, `A3_E`, `Tnew_E` and `valid_E` load 0.
  - `pc_E` still loads `pc_D`.
  - An instruction word of 0 is a sll $0 nop.
- E→M transfer:
  - `pc_M`, `ctrl_M`, `A3_M`, `valid_M` and `rt_data_M` take their E values.
  - `alu_res_M` loads `alu_res_E`.
  - `Tnew_M` loads `Tnew_E`−1, saturating at 0 (a 0 input gives 0, never 3).
- M→W transfer: `pc_W`, `ctrl_W`, `A3_W`, `valid_W` and `alu_res_W` take their M values; `mem_rdata_W` loads `mem_rdata_M`.
- No Tnew is carried into W; W results are always ready.
- Bubble counter: increments by 1 on every cycle with `flushEX`=1 and `reset`=0. It saturates at all-ones and does not wrap.
- A bubble carries `A3`=0, so the hazard unit's `A3≠0` check automatically ignores it. No special handling is needed.
- Tnew encoding that the control unit must supply on `Tnew_D`: ALU/shift/lui = 1, load = 2, store, branch, jump and no-write instructions = 0.

## Timing
- Reset: every output register goes to 0, including `pc_*`, `valid_*`, `Tnew_*` and `bubble_cnt`.
- `reset` has priority over `flushEX` and over normal transfer. During a reset cycle the counter does not increment, even if `flushEX`=1.
- Latency: a `*_D` value appears on `*_E` 1 cycle after the edge, on `*_M` after 2 and on `*_W` after 3.
- `flushEX` is sampled at the edge. The bubble is visible on the E outputs in the following cycle.
- The instruction that was in E on that same edge still moves into M normally.
- Back-to-back `flushEX` cycles insert consecutive bubbles, and each one counts.
- All outputs are registered, with no combinational path from any input. This guarantees no loop through the hazard unit.
- When reset is asserted mid-stream, all in-flight instructions are discarded. The first instruction after the reset release appears on E one edge later.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with random inputs. All outputs must read 0. Release, drive one instruction, and check it appears on E one cycle later.
- ALU flow: `instr_D`=0x02328020, `A3_D`=16, `Tnew_D`=1. Required: E shows `A3`=16/`Tnew`=1, M shows 16/0, W shows `A3_W`=16 with `valid_W`=1.
- Load flow: `A3_D`=8, `Tnew_D`=2, then drive `mem_rdata_M`=0xDEADBEEF during the M cycle. Required: `Tnew_E`=2, then `Tnew_M`=1, then `mem_rdata_W`=0xDEADBEEF.
- Flush with an older instruction in E (`A3_E`=8), drive `flushEX`=1 with `pc_D`=0x3008. Next cycle required: `A3_E`=0, `Tnew_E`=0, `valid_E`=0, `pc_E`=0x3008, `A3_M`=8, `bubble_cnt`=1.
- Saturation: with CNT_W=4, hold `flushEX`=1 for 20 cycles. `bubble_cnt` must read 15 and stay there. Separately, check that `Tnew_E`=0 gives `Tnew_M`=0.
- Reset priority: assert `reset` and `flushEX` together in the same cycle. Next cycle all outputs must be 0 and `bubble_cnt` must be 0.

Source files
------------

// File: rtl/de_mw_pipe_regs.sv
// D->E, E->M and M->W pipeline registers for the 5-stage core, with bubble
// insertion into E on flushEX and a saturating bubble counter.
module de_mw_pipe_regs #(
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flushEX,
   // D stage
   input  logic [31:0]       instr_D,
   input  logic [31:0]       pc_D,
   input  logic [31:0]       rs_data_D,
   input  logic [31:0]       rt_data_D,
   input  logic [31:0]       imm_D,
   input  logic [CTRL_W-1:0] ctrl_D,
   input  logic [4:0]        A3_D,
   input  logic [1:0]        Tnew_D,
   // E stage
   output logic [31:0]       instr_E,
   output logic [31:0]       pc_E,
   output logic [31:0]       rs_data_E,
   output logic [31:0]       rt_data_E,
   output logic [31:0]       imm_E,
   output logic [CTRL_W-1:0] ctrl_E,
   output logic [4:0]        A3_E,
   output logic [1:0]        Tnew_E,
   output logic              valid_E,
   input  logic [31:0]       alu_res_E,
   // M stage
   output logic [31:0]       pc_M,
   output logic [31:0]       alu_res_M,
   output logic [31:0]       rt_data_M,
   output logic [CTRL_W-1:0] ctrl_M,
   output logic [4:0]        A3_M,
   output logic [1:0]        Tnew_M,
   output logic              valid_M,
   input  logic [31:0]       mem_rdata_M,
   // W stage
   output logic [31:0]       pc_W,
   output logic [31:0]       alu_res_W,
   output logic [31:0]       mem_rdata_W,
   output logic [CTRL_W-1:0] ctrl_W,
   output logic [4:0]        A3_W,
   output logic              valid_W,
   // performance debug
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic [31:0]       instr_e_nxt;
   logic [31:0]       rs_data_e_nxt;
   logic [31:0]       rt_data_e_nxt;
   logic [31:0]       imm_e_nxt;
   logic [CTRL_W-1:0] ctrl_e_nxt;
   logic [4:0]        a3_e_nxt;
   logic [1:0]        tnew_e_nxt;
   logic              valid_e_nxt;
   logic [1:0]        tnew_m_nxt;
   logic [CNT_W-1:0]  bubble_cnt_nxt;

   // D->E payload: a flush turns the slot into a nop bubble but keeps the PC
   always_comb begin
      instr_e_nxt   = instr_D;
      rs_data_e_nxt = rs_data_D;
      rt_data_e_nxt = rt_data_D;
      imm_e_nxt     = imm_D;
      ctrl_e_nxt    = ctrl_D;
      a3_e_nxt      = A3_D;
      tnew_e_nxt    = Tnew_D;
      valid_e_nxt   = 1'b1;
      if (flushEX) begin
         instr_e_nxt   = 32'd0;
         rs_data_e_nxt = 32'd0;
         rt_data_e_nxt = 32'd0;
         imm_e_nxt     = 32'd0;
         ctrl_e_nxt    = '0;
         a3_e_nxt      = 5'd0;
         tnew_e_nxt    = 2'd0;
         valid_e_nxt   = 1'b0;
      end
   end

   // Tnew counts down one per stage and bottoms out at 0
   always_comb begin
      tnew_m_nxt = 2'd0;
      if (Tnew_E != 2'd0) begin
         tnew_m_nxt = Tnew_E - 2'd1;
      end
   end

   // Saturating bubble count
   always_comb begin
      bubble_cnt_nxt = bubble_cnt;
      if (flushEX && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt_nxt = bubble_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_E   <= 32'd0;
         pc_E      <= 32'd0;
         rs_data_E <= 32'd0;
         rt_data_E <= 32'd0;
         imm_E     <= 32'd0;
         ctrl_E    <= '0;
         A3_E      <= 5'd0;
         Tnew_E    <= 2'd0;
         valid_E   <= 1'b0;
      end else begin
         instr_E   <= instr_e_nxt;
         pc_E      <= pc_D;
         rs_data_E <= rs_data_e_nxt;
         rt_data_E <= rt_data_e_nxt;
         imm_E     <= imm_e_nxt;
         ctrl_E    <= ctrl_e_nxt;
         A3_E      <= a3_e_nxt;
         Tnew_E    <= tnew_e_nxt;
         valid_E   <= valid_e_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_M      <= 32'd0;
         alu_res_M <= 32'd0;
         rt_data_M <= 32'd0;
         ctrl_M    <= '0;
         A3_M      <= 5'd0;
         Tnew_M    <= 2'd0;
         valid_M   <= 1'b0;
      end else begin
         pc_M      <= pc_E;
         alu_res_M <= alu_res_E;
         rt_data_M <= rt_data_E;
         ctrl_M    <= ctrl_E;
         A3_M      <= A3_E;
         Tnew_M    <= tnew_m_nxt;
         valid_M   <= valid_E;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_W        <= 32'd0;
         alu_res_W   <= 32'd0;
         mem_rdata_W <= 32'd0;
         ctrl_W      <= '0;
         A3_W        <= 5'd0;
         valid_W     <= 1'b0;
      end else begin
         pc_W        <= pc_M;
         alu_res_W   <= alu_res_M;
         mem_rdata_W <= mem_rdata_M;
         ctrl_W      <= ctrl_M;
         A3_W        <= A3_M;
         valid_W     <= valid_M;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_cnt <= '0;
      end else begin
         bubble_cnt <= bubble_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_de_mw_pipe_regs.sv
// Self-checking bench for de_mw_pipe_regs: directed flows plus randomized
// traffic compared against a per-stage instruction-record model.
module tb_de_mw_pipe_regs;

   localparam int unsigned CTRL_W = 16;
   localparam int unsigned CNT_W  = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              flushEX;
   logic [31:0]       instr_D, pc_D, rs_data_D, rt_data_D, imm_D;
   logic [CTRL_W-1:0] ctrl_D;
   logic [4:0]        A3_D;
   logic [1:0]        Tnew_D;
   logic [31:0]       instr_E, pc_E, rs_data_E, rt_data_E, imm_E;
   logic [CTRL_W-1:0] ctrl_E;
   logic [4:0]        A3_E;
   logic [1:0]        Tnew_E;
   logic              valid_E;
   logic [31:0]       alu_res_E;
   logic [31:0]       pc_M, alu_res_M, rt_data_M;
   logic [CTRL_W-1:0] ctrl_M;
   logic [4:0]        A3_M;
   logic [1:0]        Tnew_M;
   logic              valid_M;
   logic [31:0]       mem_rdata_M;
   logic [31:0]       pc_W, alu_res_W, mem_rdata_W;
   logic [CTRL_W-1:0] ctrl_W;
   logic [4:0]        A3_W;
   logic              valid_W;
   logic [CNT_W-1:0]  bubble_cnt;

   de_mw_pipe_regs #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .flushEX(flushEX),
      .instr_D(instr_D), .pc_D(pc_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D),
      .imm_D(imm_D), .ctrl_D(ctrl_D), .A3_D(A3_D), .Tnew_D(Tnew_D),
      .instr_E(instr_E), .pc_E(pc_E), .rs_data_E(rs_data_E), .rt_data_E(rt_data_E),
      .imm_E(imm_E), .ctrl_E(ctrl_E), .A3_E(A3_E), .Tnew_E(Tnew_E), .valid_E(valid_E),
      .alu_res_E(alu_res_E),
      .pc_M(pc_M), .alu_res_M(alu_res_M), .rt_data_M(rt_data_M), .ctrl_M(ctrl_M),
      .A3_M(A3_M), .Tnew_M(Tnew_M), .valid_M(valid_M), .mem_rdata_M(mem_rdata_M),
      .pc_W(pc_W), .alu_res_W(alu_res_W), .mem_rdata_W(mem_rdata_W), .ctrl_W(ctrl_W),
      .A3_W(A3_W), .valid_W(valid_W), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   // One instruction as it sits in a stage; unused fields stay 0
   typedef struct {
      logic [31:0]       instr, pc, rs, rt, imm, alu, mem;
      logic [CTRL_W-1:0] ctrl;
      logic [4:0]        a3;
      int                tnew;
      logic              valid;
   } rec_t;

   rec_t ex, mx, wx;
   int   cnt_x;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic rec_t zero_rec();
      rec_t r;
      r.instr = '0; r.pc = '0; r.rs = '0; r.rt = '0; r.imm = '0; r.alu = '0; r.mem = '0;
      r.ctrl = '0; r.a3 = '0; r.tnew = 0; r.valid = 1'b0;
      return r;
   endfunction

   // Advance the reference by one edge from the currently driven inputs
   task automatic model_step();
      rec_t ne, nm, nw;
      if (reset) begin
         ex = zero_rec(); mx = zero_rec(); wx = zero_rec(); cnt_x = 0;
         return;
      end
      nw = zero_rec();
      nw.pc = mx.pc; nw.ctrl = mx.ctrl; nw.a3 = mx.a3; nw.valid = mx.valid;
      nw.alu = mx.alu; nw.mem = mem_rdata_M;
      nm = zero_rec();
      nm.pc = ex.pc; nm.ctrl = ex.ctrl; nm.a3 = ex.a3; nm.valid = ex.valid;
      nm.rt = ex.rt; nm.alu = alu_res_E; nm.tnew = (ex.tnew > 0) ? ex.tnew - 1 : 0;
      ne = zero_rec();
      ne.pc = pc_D;
      if (!flushEX) begin
         ne.instr = instr_D; ne.rs = rs_data_D; ne.rt = rt_data_D; ne.imm = imm_D;
         ne.ctrl = ctrl_D; ne.a3 = A3_D; ne.tnew = int'(Tnew_D); ne.valid = 1'b1;
      end else if (cnt_x < CNT_MAX) begin
         cnt_x++;
      end
      ex = ne; mx = nm; wx = nw;
   endtask

   task automatic compare_all();
      chk("instr_E", 64'(instr_E), 64'(ex.instr));
      chk("pc_E", 64'(pc_E), 64'(ex.pc));
      chk("rs_data_E", 64'(rs_data_E), 64'(ex.rs));
      chk("rt_data_E", 64'(rt_data_E), 64'(ex.rt));
      chk("imm_E", 64'(imm_E), 64'(ex.imm));
      chk("ctrl_E", 64'(ctrl_E), 64'(ex.ctrl));
      chk("A3_E", 64'(A3_E), 64'(ex.a3));
      chk("Tnew_E", 64'(Tnew_E), 64'(ex.tnew));
      chk("valid_E", 64'(valid_E), 64'(ex.valid));
      chk("pc_M", 64'(pc_M), 64'(mx.pc));
      chk("alu_res_M", 64'(alu_res_M), 64'(mx.alu));
      chk("rt_data_M", 64'(rt_data_M), 64'(mx.rt));
      chk("ctrl_M", 64'(ctrl_M), 64'(mx.ctrl));
      chk("A3_M", 64'(A3_M), 64'(mx.a3));
      chk("Tnew_M", 64'(Tnew_M), 64'(mx.tnew));
      chk("valid_M", 64'(valid_M), 64'(mx.valid));
      chk("pc_W", 64'(pc_W), 64'(wx.pc));
      chk("alu_res_W", 64'(alu_res_W), 64'(wx.alu));
      chk("mem_rdata_W", 64'(mem_rdata_W), 64'(wx.mem));
      chk("ctrl_W", 64'(ctrl_W), 64'(wx.ctrl));
      chk("A3_W", 64'(A3_W), 64'(wx.a3));
      chk("valid_W", 64'(valid_W), 64'(wx.valid));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(cnt_x));
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic rand_inputs();
      instr_D = $urandom; pc_D = $urandom; rs_data_D = $urandom; rt_data_D = $urandom;
      imm_D = $urandom; ctrl_D = CTRL_W'($urandom); A3_D = 5'($urandom);
      Tnew_D = 2'($urandom); alu_res_E = $urandom; mem_rdata_M = $urandom;
   endtask

   task automatic drive_d(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [4:0] a3, input logic [1:0] tnew);
      rand_inputs();
      instr_D = instr; pc_D = pc; A3_D = a3; Tnew_D = tnew; flushEX = 1'b0;
   endtask

   initial begin
      ex = zero_rec(); mx = zero_rec(); wx = zero_rec(); cnt_x = 0;
      reset = 1'b1; flushEX = 1'b0;
      rand_inputs();

      // Reset held two cycles under random inputs
      for (int i = 0; i < 2; i++) begin
         rand_inputs();
         flushEX = 1'($urandom);
         cycle();
      end
      chk("rst_valid_E", 64'(valid_E), 64'd0);
      chk("rst_pc_W", 64'(pc_W), 64'd0);
      chk("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
      reset = 1'b0;
      drive_d(32'h1234_5678, 32'h0000_3000, 5'd3, 2'd1);
      cycle();
      chk("first_instr_E", 64'(instr_E), 64'h1234_5678);
      chk("first_valid_E", 64'(valid_E), 64'd1);

      // ALU flow
      drive_d(32'h0232_8020, 32'h0000_3004, 5'd16, 2'd1);
      cycle();
      chk("alu_A3_E", 64'(A3_E), 64'd16);
      chk("alu_Tnew_E", 64'(Tnew_E), 64'd1);
      drive_d(32'd0, 32'h0000_3008, 5'd0, 2'd0);
      cycle();
      chk("alu_A3_M", 64'(A3_M), 64'd16);
      chk("alu_Tnew_M", 64'(Tnew_M), 64'd0);
      drive_d(32'd0, 32'h0000_300c, 5'd0, 2'd0);
      cycle();
      chk("alu_A3_W", 64'(A3_W), 64'd16);
      chk("alu_valid_W", 64'(valid_W), 64'd1);

      // Load flow
      drive_d(32'h8c08_0000, 32'h0000_3010, 5'd8, 2'd2);
      cycle();
      chk("ld_Tnew_E", 64'(Tnew_E), 64'd2);
      drive_d(32'd0, 32'h0000_3014, 5'd0, 2'd0);
      cycle();
      chk("ld_Tnew_M", 64'(Tnew_M), 64'd1);
      drive_d(32'd0, 32'h0000_3018, 5'd0, 2'd0);
      mem_rdata_M = 32'hDEAD_BEEF;
      cycle();
      chk("ld_mem_rdata_W", 64'(mem_rdata_W), 64'hDEAD_BEEF);

      // Flush behind an older instruction in E
      drive_d(32'h0100_4020, 32'h0000_3004, 5'd8, 2'd1);
      cycle();
      chk("fl_pre_A3_E", 64'(A3_E), 64'd8);
      rand_inputs();
      pc_D = 32'h0000_3008; flushEX = 1'b1;
      cycle();
      chk("fl_A3_E", 64'(A3_E), 64'd0);
      chk("fl_Tnew_E", 64'(Tnew_E), 64'd0);
      chk("fl_valid_E", 64'(valid_E), 64'd0);
      chk("fl_pc_E", 64'(pc_E), 64'h3008);
      chk("fl_A3_M", 64'(A3_M), 64'd8);
      chk("fl_bubble_cnt", 64'(bubble_cnt), 64'd1);

      // Counter saturation: 20 consecutive flushes on top of the one above
      for (int i = 0; i < 20; i++) begin
         rand_inputs();
         flushEX = 1'b1;
         cycle();
         chk("sat_bubble_cnt", 64'(bubble_cnt), 64'((i + 2 > CNT_MAX) ? CNT_MAX : i + 2));
      end
      chk("sat_final", 64'(bubble_cnt), 64'd15);

      // Tnew 0 stays 0 into M
      drive_d(32'h0000_0000, 32'h0000_4000, 5'd5, 2'd0);
      cycle();
      drive_d(32'h0000_0000, 32'h0000_4004, 5'd0, 2'd0);
      cycle();
      chk("tnew0_Tnew_M", 64'(Tnew_M), 64'd0);
      chk("tnew0_A3_M", 64'(A3_M), 64'd5);

      // Reset wins over flush in the same cycle
      rand_inputs();
      reset = 1'b1; flushEX = 1'b1;
      cycle();
      chk("rp_bubble_cnt", 64'(bubble_cnt), 64'd0);
      chk("rp_pc_E", 64'(pc_E), 64'd0);
      chk("rp_A3_M", 64'(A3_M), 64'd0);
      chk("rp_valid_W", 64'(valid_W), 64'd0);
      reset = 1'b0;

      // Random traffic with occasional mid-stream resets
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         flushEX = ($urandom_range(0, 3) == 0);
         reset   = ($urandom_range(0, 39) == 0);
         cycle();
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
